button_press_classifier: RTL and testbench
==========================================

// Module: button_press_classifier
// PURPOSE
//  Sits directly downstream of the debounce filter; consumes its clean o_Debounced level.
//  Detects press edges, counts presses and classifies each press as short or long by hold time.
//  Outputs are single-cycle event pulses for LED/7-seg/control logic on the same clock.
// PARAMETERS
//  LONG_PRESS_CYCLES  25_000_000  consecutive high samples that make a long press (>=2)
//  DOUBLE_GAP_CYCLES   6_250_000  max low samples between presses for a double press (>=2; macro only)
//  Counter width: $clog2 of the larger of the two parameters, plus 1 bit.
// PORTS
//  i_Clk           in   1  system clock; all logic on rising edge
//  i_Rst_L         in   1  asynchronous, active-low reset
//  i_Debounced     in   1  clean button level from debounce filter (1 = pressed)
//  o_Press         out  1  1-cycle pulse on every press (rising edge)
//  o_Short_Press   out  1  1-cycle pulse when a press is classified short
//  o_Long_Press    out  1  1-cycle pulse when the hold reaches LONG_PRESS_CYCLES
//  o_Held          out  1  level: high from o_Long_Press until release
//  o_Double_Press  out  1  1-cycle pulse on second press within gap (tied 0 without macro)
//  o_Press_Count   out  8  running count of o_Press pulses
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, counter 0, all outputs 0, r_Prev = 1.
//    r_Prev = 1 means a button already held at reset release is NOT a press.
//  - Edge detect: rise = i_Debounced & ~r_Prev; fall = ~i_Debounced & r_Prev; r_Prev <= i_Debounced.
//  - All outputs registered: pulse visible the cycle after the clock edge that sampled the cause.
//  - IDLE: rise -> PRESSED, o_Press=1, count <= 1 (rise sample counts as first high sample).
//    Fall ignored.
//  - PRESSED: each high sample increments count.
//    Count reaches LONG_PRESS_CYCLES -> LONG_HELD, o_Long_Press=1, o_Held=1.
//    Low sample before that:
//      macro off: o_Short_Press=1, -> IDLE.
//      macro on: -> WAIT_SECOND, count <= 1 (release sample counts as first low sample).
//  - LONG_HELD: o_Held stays 1; low sample -> o_Held=0, -> IDLE. No short pulse ever follows a long press.
//  - WAIT_SECOND (macro on only): each low sample increments count.
//    rise while count < DOUBLE_GAP_CYCLES: o_Double_Press=1, o_Press=1, -> DBL_HELD.
//    Count reaches DOUBLE_GAP_CYCLES: o_Short_Press=1 (deferred), -> IDLE.
//    A rise on the next sample is then a fresh press from IDLE.
//  - DBL_HELD (macro on only): wait for low sample -> IDLE. No short/long classification of the second press.
//  - o_Press_Count increments with each o_Press; wraps 255 -> 0.
//  - At most one of o_Short_Press/o_Long_Press/o_Double_Press is high in any cycle.
//  - Reset mid-operation: all state and outputs cleared immediately; o_Held drops asynchronously.
//  - Unused state encodings recover to IDLE.
// CONFIGURATION
//  DOUBLE_PRESS_EN defined: WAIT_SECOND/DBL_HELD states and gap counting are compiled in.
//    Short-press pulse is deferred by up to DOUBLE_GAP_CYCLES low samples.
//  DOUBLE_PRESS_EN undefined: 3-state FSM (IDLE/PRESSED/LONG_HELD).
//    Short pulse is issued on the release sample; o_Double_Press is driven constant 0.
// TESTING  (bench override: LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=4; 4-cycle clock period)
//  1. Hold i_Debounced=1 through reset release -> no o_Press.
//     Then drop to 0, raise to 1 -> one o_Press pulse, o_Press_Count=1.
//  2. Macro off: high for 3 samples, then low -> o_Short_Press one pulse the cycle after the release sample.
//     o_Long_Press and o_Held stay 0.
//  3. High for 10 samples -> o_Long_Press pulse after 8th high sample; o_Held=1 until cycle after release.
//     No o_Short_Press.
//  4. Macro on: high 2, low 2, high 2 -> o_Double_Press pulse, o_Press_Count +2, no short/long.
//     Then high 2, low 4 -> o_Short_Press after 4th low sample.
//  5. Issue 256 short presses -> o_Press_Count returns to 0 with no glitch on other outputs.
//  6. Drive i_Rst_L=0 mid-cycle while in LONG_HELD -> o_Held and all outputs 0 before next clock edge.
//     After release, held button produces no o_Press.

Source files
------------

// File: rtl/button_press_classifier_if.sv
// ============================================================================
// Module   : button_press_classifier_if
// Brief    : Debounced level in, press-event pulses/count out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_press_classifier_if;
    logic       i_Debounced;
    logic       o_Press;
    logic       o_Short_Press;
    logic       o_Long_Press;
    logic       o_Held;
    logic       o_Double_Press;
    logic [7:0] o_Press_Count;

    // master: debounce filter / event consumer side
    modport master (
        output i_Debounced,
        input  o_Press, o_Short_Press, o_Long_Press, o_Held, o_Double_Press, o_Press_Count
    );

    // slave: the classifier itself
    modport slave (
        input  i_Debounced,
        output o_Press, o_Short_Press, o_Long_Press, o_Held, o_Double_Press, o_Press_Count
    );
endinterface

`default_nettype wire

// File: rtl/button_press_classifier.sv
// ============================================================================
// Module   : button_press_classifier
// Brief    : Counts presses and classifies them short/long (and double when
//            DOUBLE_PRESS_EN is defined). All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_press_classifier #(
    parameter int LONG_PRESS_CYCLES = 25_000_000,
    parameter int DOUBLE_GAP_CYCLES = 6_250_000
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    button_press_classifier_if.slave      bus
);

    localparam int c_MAX_CYCLES = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                                  LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_LONG = c_CNT_W'(LONG_PRESS_CYCLES);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_PRESSED     = 3'd1;
    localparam logic [2:0] c_LONG_HELD   = 3'd2;
`ifdef DOUBLE_PRESS_EN
    localparam logic [2:0] c_WAIT_SECOND = 3'd3;
    localparam logic [2:0] c_DBL_HELD    = 3'd4;
    localparam logic [c_CNT_W-1:0] c_GAP = c_CNT_W'(DOUBLE_GAP_CYCLES);
`endif

    logic [2:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               r_prev;
    logic               w_rise;

    logic w_press, w_short, w_long, w_held, w_double;
    logic r_press, r_short, r_long, r_held, r_double;
    logic [7:0] r_press_count;

    // Previous sample resets to 1 so a button held through reset is not a press
    assign w_rise    = bus.i_Debounced & ~r_prev;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_prev        <= 1'b1;
            r_press       <= 1'b0;
            r_short       <= 1'b0;
            r_long        <= 1'b0;
            r_held        <= 1'b0;
            r_double      <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_prev        <= bus.i_Debounced;
            r_press       <= w_press;
            r_short       <= w_short;
            r_long        <= w_long;
            r_held        <= w_held;
            r_double      <= w_double;
            r_press_count <= r_press_count + {7'd0, w_press};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = c_PRESSED;
                    w_cnt_nxt   = c_CNT_W'(1);
                end
            end
            c_PRESSED: begin
                if (bus.i_Debounced) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_LONG) w_state_nxt = c_LONG_HELD;
                end else begin
`ifdef DOUBLE_PRESS_EN
                    // Release sample is the first low sample of the gap
                    w_state_nxt = c_WAIT_SECOND;
                    w_cnt_nxt   = c_CNT_W'(1);
`else
                    w_state_nxt = c_IDLE;
`endif
                end
            end
            c_LONG_HELD: begin
                if (!bus.i_Debounced) w_state_nxt = c_IDLE;
            end
`ifdef DOUBLE_PRESS_EN
            c_WAIT_SECOND: begin
                if (bus.i_Debounced) begin
                    w_state_nxt = c_DBL_HELD;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_GAP) w_state_nxt = c_IDLE;
                end
            end
            c_DBL_HELD: begin
                if (!bus.i_Debounced) w_state_nxt = c_IDLE;
            end
`endif
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_press  = (r_state == c_IDLE) && w_rise;
        w_long   = (r_state == c_PRESSED) && bus.i_Debounced && (w_cnt_inc == c_LONG);
        w_held   = w_long || ((r_state == c_LONG_HELD) && bus.i_Debounced);
        w_short  = 1'b0;
        w_double = 1'b0;
`ifdef DOUBLE_PRESS_EN
        if (r_state == c_WAIT_SECOND) begin
            w_press  = bus.i_Debounced;
            w_double = bus.i_Debounced;
            w_short  = !bus.i_Debounced && (w_cnt_inc == c_GAP);
        end
`else
        w_short  = (r_state == c_PRESSED) && !bus.i_Debounced;
`endif
    end

    assign bus.o_Press        = r_press;
    assign bus.o_Short_Press  = r_short;
    assign bus.o_Long_Press   = r_long;
    assign bus.o_Held         = r_held;
    assign bus.o_Press_Count  = r_press_count;
`ifdef DOUBLE_PRESS_EN
    assign bus.o_Double_Press = r_double;
`else
    assign bus.o_Double_Press = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_press_classifier.sv
// ============================================================================
// Module   : tb_button_press_classifier
// Brief    : Self-checking bench for button_press_classifier (LONG=8, GAP=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_button_press_classifier;

    localparam int LONG = 8;
    localparam int GAP  = 4;

    logic i_Clk   = 1'b0;
    logic i_Rst_L = 1'b0;

    button_press_classifier_if bus();

    button_press_classifier #(
        .LONG_PRESS_CYCLES (LONG),
        .DOUBLE_GAP_CYCLES (GAP)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .bus     (bus)
    );

    always #2 i_Clk = ~i_Clk;

    typedef struct packed {
        logic deb;
        logic press;
        logic shrt;
        logic lng;
        logic held;
        logic dbl;
    } vec_t;

    typedef struct {
        logic [12:0] exp;
        string       tag;
    } sb_t;

    vec_t       tbl[$];
    sb_t        sbq[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt  = 8'd0;

    // {press, short, long, held, double, count}
    function automatic logic [12:0] dut_out();
        return {bus.o_Press, bus.o_Short_Press, bus.o_Long_Press, bus.o_Held,
                bus.o_Double_Press, bus.o_Press_Count};
    endfunction

    task automatic check(input string tag, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got p/s/l/h/d/cnt=%b want %b", tag, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input vec_t v, input string tag);
        sb_t e;
        bus.i_Debounced = v.deb;
        if (v.press) exp_cnt = exp_cnt + 8'd1;
        e.exp = {v.press, v.shrt, v.lng, v.held, v.dbl, exp_cnt};
        e.tag = tag;
        sbq.push_back(e);
        @(posedge i_Clk);
        #1;
        e = sbq.pop_front();
        check(e.tag, dut_out(), e.exp);
        @(negedge i_Clk);
    endtask

    function automatic void add(input logic d, p, s, l, h, db);
        tbl.push_back({d, p, s, l, h, db});
    endfunction

    function automatic void add_n(input int n, input logic d);
        for (int k = 0; k < n; k++) add(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Press lasting 'highs' samples (< LONG), released until the short pulse.
    function automatic void short_press(input int highs);
        add(1, 1, 0, 0, 0, 0);
        add_n(highs - 1, 1'b1);
`ifdef DOUBLE_PRESS_EN
        add_n(GAP - 1, 1'b0);
`endif
        add(0, 0, 1, 0, 0, 0);
    endfunction

    function automatic void long_press(input int highs);
        add(1, 1, 0, 0, 0, 0);
        add_n(LONG - 2, 1'b1);
        add(1, 0, 0, 1, 1, 0);
        for (int k = 0; k < highs - LONG; k++) add(1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0);
    endfunction

    task automatic run_table(input string pfx);
        for (int i = 0; i < tbl.size(); i++) drive(tbl[i], $sformatf("%s%0d", pfx, i));
        tbl.delete();
    endtask

    initial begin
        bus.i_Debounced = 1'b1;
        repeat (2) @(negedge i_Clk);
        check("reset_state", dut_out(), 13'd0);
        i_Rst_L = 1'b1;

        add_n(2, 1'b1);          // held through reset release: no press
        add_n(1, 1'b0);
        short_press(1);
        add_n(1, 1'b0);
        short_press(3);
        short_press(7);          // one short of long threshold
        long_press(10);
        long_press(8);           // exactly at threshold
`ifdef DOUBLE_PRESS_EN
        add(1, 1, 0, 0, 0, 0); add_n(1, 1'b1); add_n(2, 1'b0);
        add(1, 1, 0, 0, 0, 1); add_n(1, 1'b1); add_n(1, 1'b0);
        short_press(2);          // short after 4th low sample
        add(1, 1, 0, 0, 0, 0); add_n(3, 1'b0);
        add(1, 1, 0, 0, 0, 1); add_n(1, 1'b0);
        short_press(1);
        short_press(1);          // rise right after deferred short is a fresh press
`endif
        run_table("tbl");

        // Async reset while in the long-held state
        drive({1'b1, 1'b1, 4'b0000}, "t6_press");
        for (int k = 0; k < LONG - 2; k++) drive(6'b100000, "t6_hold");
        drive(6'b100110, "t6_long");
        drive(6'b100010, "t6_held");
        #1 i_Rst_L = 1'b0;
        #0.5 check("t6_async_clear", dut_out(), 13'd0);
        exp_cnt = 8'd0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        for (int k = 0; k < 3; k++) drive(6'b100000, "t6_held_after_reset");
        drive(6'b000000, "t6_release");

        // Count wraps back to zero after 256 presses
        for (int k = 0; k < 256; k++) short_press(1);
        run_table("wrap");
        check("wrap_count_zero", {5'd0, bus.o_Press_Count}, 13'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
